cpu_qsys_cpu_oci_dct_packer: RTL



---
 rtl/cpu_qsys_cpu_oci_dct_packer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cpu_qsys_cpu_oci_dct_packer.sv
// Compressed-trace packer: packs 1..IN_SLOTS-slot fragments LSB-first into
// SLOTS-slot trace words, then drains the partial word at end of test.
module cpu_qsys_cpu_oci_dct_packer #(
    parameter int SLOT_W   = 2,
    parameter int SLOTS    = 15,
    parameter int IN_SLOTS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SLOT_W*IN_SLOTS-1:0] in_data,
    input  logic [1:0]                in_len,
    input  logic                      flush_req,
    output logic                      dct_valid,
    input  logic                      dct_ready,
    output logic [SLOT_W*SLOTS-1:0]   dct_buffer,
    output logic [3:0]                dct_count,
    output logic                      test_ending,
    output logic                      test_has_ended
);
    localparam int W  = SLOT_W * SLOTS;
    localparam int IW = SLOT_W * IN_SLOTS;
    // Highest fill level that can still absorb a maximum-length fragment
    // without completing a word.
    localparam logic [3:0] SAFE_CNT = 4'(SLOTS - IN_SLOTS - 1);

    typedef enum logic [1:0] {FILL, DRAIN, ENDED} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [3:0]     acc_cnt_q, acc_cnt_d;
    logic [W-1:0]   buf_q, buf_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           valid_q, valid_d;

    logic           out_free;
    logic           accept;
    logic [IW-1:0]  frag;
    logic [7:0]     shamt;
    logic [W+IW-1:0] merged;
    logic [4:0]     total;

    assign out_free = !valid_q || dct_ready;
    // in_ready is gated by reset so it reads 0 while reset is held.
    assign in_ready = !reset && (state_q == FILL) && (acc_cnt_q <= SAFE_CNT || out_free);
    assign accept   = in_valid && in_ready;

    assign dct_valid      = valid_q;
    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign test_ending    = (state_q == DRAIN);
    assign test_has_ended = (state_q == ENDED);

    // Mask the fragment to its declared length and splice it above the
    // current fill; bits beyond W are the carry-over into the next word.
    always_comb begin
        frag = '0;
        for (int k = 0; k < IN_SLOTS; k++) begin
            if (k <= int'(in_len)) frag[k*SLOT_W +: SLOT_W] = in_data[k*SLOT_W +: SLOT_W];
        end
        shamt  = 8'(acc_cnt_q) * 8'(SLOT_W);
        merged = {{IW{1'b0}}, acc_q} | ({{W{1'b0}}, frag} << shamt);
        total  = 5'(acc_cnt_q) + 5'(in_len) + 5'd1;
    end

    // Next-state: packing, output register handshake and drain sequencing.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        if (valid_q && dct_ready) valid_d = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (total < 5'(SLOTS)) begin
                        acc_d     = merged[W-1:0];
                        acc_cnt_d = total[3:0];
                    end else begin
                        buf_d     = merged[W-1:0];
                        cnt_d     = 4'(SLOTS);
                        valid_d   = 1'b1;
                        acc_d     = W'(merged[W+IW-1:W]);
                        acc_cnt_d = 4'(total - 5'(SLOTS));
                    end
                end
                if (flush_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (acc_cnt_q != 4'd0 && out_free) begin
                    buf_d     = acc_q;
                    cnt_d     = acc_cnt_q;
                    valid_d   = 1'b1;
                    acc_d     = '0;
                    acc_cnt_d = 4'd0;
                end else if (acc_cnt_q == 4'd0 && !valid_q) begin
                    state_d = ENDED;
                end
            end
            default: ;
        endcase
    end

    // State registers; reset discards any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FILL;
            acc_q     <= '0;
            acc_cnt_q <= 4'd0;
            buf_q     <= '0;
            cnt_q     <= 4'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_cnt_q <= acc_cnt_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
        end
    end
endmodule
